// File: rtl/counter_pkg.sv
// Shared types and limits for the parametrised counter.
// Optional auto-reload is built when COUNTER_AUTORELOAD_EN is defined.
package counter_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_DEC,
    CMD_INC,
    CMD_HALF,
    CMD_DOUBLE
  } cmd_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/counter_cmd_prio.sv
// Fixed-priority encoder from the five command strobes to one command.
// Optional auto-reload is built when COUNTER_AUTORELOAD_EN is defined.
module counter_cmd_prio
  import counter_pkg::*;
(
  input  logic latch,
  input  logic dec,
  input  logic inc,
  input  logic divide_by_two,
  input  logic multiply_by_two,
  output cmd_t cmd
);

  always_comb begin
    cmd = CMD_NONE;
    if (latch)                cmd = CMD_LOAD;
    else if (dec)             cmd = CMD_DEC;
    else if (inc)             cmd = CMD_INC;
    else if (divide_by_two)   cmd = CMD_HALF;
    else if (multiply_by_two) cmd = CMD_DOUBLE;
  end

endmodule

// File: rtl/counter_param.sv
// Saturating load/dec/inc/halve/double counter with status pulses.
// COUNTER_AUTORELOAD_EN adds a reload register turning it into a down-timer.
module counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             latch,
  input  logic             dec,
  input  logic             inc,
  input  logic             divide_by_two,
  input  logic             multiply_by_two,
`ifdef COUNTER_AUTORELOAD_EN
  input  logic             reload_en,
  output logic             expired,
`endif
  output logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             full,
  output logic             sat
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("counter_param: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] ONES = '1;

  cmd_t             cmd;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             sat_d;

`ifdef COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             exp_d;
`endif

  counter_cmd_prio u_prio (
    .latch           (latch),
    .dec             (dec),
    .inc             (inc),
    .divide_by_two   (divide_by_two),
    .multiply_by_two (multiply_by_two),
    .cmd             (cmd)
  );

  always_comb begin
    value_d = value_q;
    sat_d   = 1'b0;
`ifdef COUNTER_AUTORELOAD_EN
    exp_d   = 1'b0;
`endif
    unique case (cmd)
      CMD_LOAD: value_d = in;
      CMD_DEC: begin
        if (value_q != '0) begin
          value_d = value_q - 1'b1;
        end
`ifdef COUNTER_AUTORELOAD_EN
        else if (reload_en) begin
          value_d = reload_q;
          exp_d   = 1'b1;
        end
`endif
        else begin
          sat_d = 1'b1;
        end
      end
      CMD_INC: begin
        if (value_q != ONES) value_d = value_q + 1'b1;
        else sat_d = 1'b1;
      end
      CMD_HALF: value_d = value_q >> 1;
      CMD_DOUBLE: begin
        // MSB set means the shift would lose a bit: clamp instead
        if (value_q[WIDTH-1]) begin
          value_d = ONES;
          sat_d   = 1'b1;
        end else begin
          value_d = value_q << 1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      sat     <= 1'b0;
    end else begin
      value_q <= value_d;
      sat     <= sat_d;
    end
  end

`ifdef COUNTER_AUTORELOAD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
      expired  <= 1'b0;
    end else begin
      if (cmd == CMD_LOAD) reload_q <= in;
      expired <= exp_d;
    end
  end
`endif

  assign value = value_q;
  assign zero  = (value_q == '0);
  assign full  = (value_q == ONES);

endmodule

// File: tb/tb_counter_param.sv
// Random and directed checks of counter_param against an arithmetic model.
// Reload paths are exercised when COUNTER_AUTORELOAD_EN is defined.
module tb_counter_param;

  localparam longint MAXV = 255;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in8 = '0;
  logic [15:0] in16 = '0;
  logic        latch = 1'b0;
  logic        dec = 1'b0;
  logic        inc = 1'b0;
  logic        half = 1'b0;
  logic        dbl = 1'b0;
  logic        ren = 1'b0;
  logic [7:0]  value8;
  logic        zero8, full8, sat8;
  logic [15:0] value16;
  logic        zero16, full16, sat16;
  logic        exp8, exp16;

  int total = 0;
  int bad = 0;

  longint mval = 0;
  longint mrel = 0;
  bit     msat = 0;
  bit     mexp = 0;

  always #5 clock = ~clock;

  counter_param #(.WIDTH(8)) u_dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in              (in8),
    .latch           (latch),
    .dec             (dec),
    .inc             (inc),
    .divide_by_two   (half),
    .multiply_by_two (dbl),
`ifdef COUNTER_AUTORELOAD_EN
    .reload_en       (ren),
    .expired         (exp8),
`endif
    .value           (value8),
    .zero            (zero8),
    .full            (full8),
    .sat             (sat8)
  );

  counter_param #(.WIDTH(16)) u_dut16 (
    .clock           (clock),
    .reset_n         (reset_n),
    .in              (in16),
    .latch           (latch),
    .dec             (dec),
    .inc             (inc),
    .divide_by_two   (half),
    .multiply_by_two (dbl),
`ifdef COUNTER_AUTORELOAD_EN
    .reload_en       (ren),
    .expired         (exp16),
`endif
    .value           (value16),
    .zero            (zero16),
    .full            (full16),
    .sat             (sat16)
  );

`ifndef COUNTER_AUTORELOAD_EN
  assign exp8  = 1'b0;
  assign exp16 = 1'b0;
`endif

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge reset_n) begin
    mval = 0; mrel = 0; msat = 0; mexp = 0;
  end

  // Reference model: spec rules as plain integer arithmetic
  always @(posedge clock) begin
    if (!reset_n) begin
      mval = 0; mrel = 0; msat = 0; mexp = 0;
    end else begin
      msat = 0;
      mexp = 0;
      if (latch) begin
        mval = in8;
        mrel = in8;
      end else if (dec) begin
        if (mval > 0) mval = mval - 1;
        else if (ren) begin mval = mrel; mexp = 1; end
        else msat = 1;
      end else if (inc) begin
        if (mval < MAXV) mval = mval + 1;
        else msat = 1;
      end else if (half) begin
        mval = mval / 2;
      end else if (dbl) begin
        if (2 * mval > MAXV) begin mval = MAXV; msat = 1; end
        else mval = 2 * mval;
      end
    end
    #1;
    chk("value", value8, mval);
    chk("zero", zero8, mval == 0);
    chk("full", full8, mval == MAXV);
    chk("sat", sat8, msat);
    chk("expired", exp8, mexp);
  end

  task automatic cyc(input logic l, input logic d, input logic i,
                     input logic h, input logic m, input logic [7:0] v);
    @(negedge clock);
    latch = l; dec = d; inc = i; half = h; dbl = m; in8 = v;
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, in8);
  endtask

  initial begin
    #12;
    @(negedge clock);
    reset_n = 1'b1;
    chk("rst_value", value8, 0);
    chk("rst_zero", zero8, 1);
    chk("rst_full", full8, 0);
    chk("rst_sat", sat8, 0);

    idle();
    chk("idle_value", value8, 0);
    cyc(1, 0, 0, 0, 0, 8'hA5);
    chk("ld_a5", value8, 8'hA5);
    chk("ld_a5_zero", zero8, 0);

    cyc(1, 0, 0, 0, 0, 8'h03);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("dec_2", value8, 2);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("dec_1", value8, 1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("dec_0", value8, 0);
    chk("dec_0_sat", sat8, 0);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("dec_hold", value8, 0);
    chk("dec_sat", sat8, 1);
    idle();
    chk("dec_sat_end", sat8, 0);

    cyc(1, 0, 0, 0, 0, 8'hFE);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("inc_ff", value8, 8'hFF);
    chk("inc_full", full8, 1);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("inc_hold", value8, 8'hFF);
    chk("inc_sat", sat8, 1);
    cyc(0, 0, 0, 1, 0, 8'h00);
    chk("half_7f", value8, 8'h7F);
    chk("half_sat", sat8, 0);
    cyc(0, 0, 0, 0, 1, 8'h00);
    chk("dbl_fe", value8, 8'hFE);
    cyc(0, 0, 0, 0, 1, 8'h00);
    chk("dbl_ff", value8, 8'hFF);
    chk("dbl_sat", sat8, 1);

    cyc(1, 1, 1, 0, 0, 8'h10);
    chk("prio_ld", value8, 8'h10);
    chk("prio_sat", sat8, 0);
    cyc(0, 1, 1, 0, 0, 8'h00);
    chk("prio_dec", value8, 8'h0F);

    // asynchronous reset between edges
    cyc(1, 0, 0, 0, 0, 8'h5A);
    @(negedge clock);
    latch = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_value", value8, 0);
    chk("arst_zero", zero8, 1);
    @(negedge clock);
    reset_n = 1'b1;

    in16 = 16'h0003;
    cyc(1, 0, 0, 0, 0, 8'h03);
    chk("w16_ld", value16, 16'h0003);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("w16_2", value16, 2);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("w16_0", value16, 0);
    chk("w16_zero", zero16, 1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("w16_hold", value16, 0);
    chk("w16_sat", sat16, 1);
    idle();
    chk("w16_sat_end", sat16, 0);
    chk("w16_full", full16, 0);

`ifdef COUNTER_AUTORELOAD_EN
    ren = 1'b1;
    cyc(1, 0, 0, 0, 0, 8'h02);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("ar_1", value8, 1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("ar_0", value8, 0);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("ar_2", value8, 2);
    chk("ar_exp", exp8, 1);
    chk("ar_nosat", sat8, 0);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("ar_exp_end", exp8, 0);
    cyc(0, 1, 0, 0, 0, 8'h00);
    ren = 1'b0;
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("ar_off_hold", value8, 0);
    chk("ar_off_sat", sat8, 1);
    chk("ar_off_exp", exp8, 0);
`endif

    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      latch = ($urandom_range(0, 9) == 0);
      dec   = ($urandom_range(0, 3) == 0);
      inc   = ($urandom_range(0, 3) == 0);
      half  = ($urandom_range(0, 5) == 0);
      dbl   = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0: in8 = 8'h00;
        1: in8 = 8'h01;
        2: in8 = 8'hFF;
        3: in8 = 8'h80;
        default: in8 = 8'($urandom);
      endcase
      in16 = 16'($urandom);
`ifdef COUNTER_AUTORELOAD_EN
      ren = ($urandom_range(0, 2) != 0);
`endif
      if ($urandom_range(0, 79) == 0) begin
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    @(negedge clock);
    latch = 0; dec = 0; inc = 0; half = 0; dbl = 0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
